// File: rtl/stopwatch_bcd_ctl.sv
// rtl/stopwatch_bcd_ctl.sv - mm:ss BCD stopwatch with debounced start/lap buttons and tick-paced counting
`timescale 1ns/1ps
module stopwatch_bcd_ctl #(
    parameter logic [15:0] DEB_LEN = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       wrap
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

    state_t      state;
    logic [2:0]  t_sync;
    logic        tick_p;
    logic [1:0]  btn_raw;
    logic [1:0]  b_s1;
    logic [1:0]  b_s2;
    logic [1:0]  b_deb;
    logic [1:0]  b_deb_q;
    logic [15:0] b_cnt [2];
    logic        start_p;
    logic        lap_p;
    logic [15:0] cnt;
    logic [15:0] lap_cnt;
    logic [15:0] cnt_inc;
    logic        roll;

    // t_sync[1:0] is the synchronizer, t_sync[2] the previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_sync <= '0;
        end else begin
            t_sync <= {t_sync[1:0], tick};
        end
    end
    assign tick_p = t_sync[1] & ~t_sync[2];

    assign btn_raw = {btn_lap, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_s1     <= '0;
            b_s2     <= '0;
            b_deb    <= '0;
            b_deb_q  <= '0;
            b_cnt[0] <= '0;
            b_cnt[1] <= '0;
        end else begin
            b_s1    <= btn_raw;
            b_s2    <= b_s1;
            b_deb_q <= b_deb;
            for (int i = 0; i < 2; i++) begin
                if (b_s2[i] == b_deb[i]) begin
                    b_cnt[i] <= '0;
                end else if (b_cnt[i] == DEB_LEN - 16'd1) begin
                    b_deb[i] <= b_s2[i];
                    b_cnt[i] <= '0;
                end else begin
                    b_cnt[i] <= b_cnt[i] + 16'd1;
                end
            end
        end
    end
    assign start_p = b_deb[0] & ~b_deb_q[0];
    assign lap_p   = b_deb[1] & ~b_deb_q[1];

    // BCD ripple increment: ss ones, ss tens (0-5), mm ones, mm tens (0-5)
    always_comb begin
        cnt_inc = cnt;
        roll    = 1'b0;
        if (cnt[3:0] != 4'd9) begin
            cnt_inc[3:0] = cnt[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt[7:4] != 4'd5) begin
                cnt_inc[7:4] = cnt[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt[11:8] != 4'd9) begin
                    cnt_inc[11:8] = cnt[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt[15:12] != 4'd5) begin
                        cnt_inc[15:12] = cnt[15:12] + 4'd1;
                    end else begin
                        cnt_inc[15:12] = 4'd0;
                        roll           = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= S_IDLE;
            cnt                    <= '0;
            lap_cnt                <= '0;
            wrap                   <= 1'b0;
            {dig3, dig2, dig1, dig0} <= '0;
        end else begin
            wrap <= 1'b0;
            if (tick_p && (state == S_RUN || state == S_LAP)) begin
                cnt  <= cnt_inc;
                wrap <= roll;
            end
            case (state)
                S_IDLE: begin
                    if (start_p) state <= S_RUN;
                end
                S_RUN: begin
                    if (start_p) begin
                        state <= S_PAUSE;
                    end else if (lap_p) begin
                        state   <= S_LAP;
                        lap_cnt <= cnt;
                    end
                end
                S_PAUSE: begin
                    if (start_p) begin
                        state <= S_RUN;
                    end else if (lap_p) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                S_LAP: begin
                    if (start_p) begin
                        state <= S_PAUSE;
                    end else if (lap_p) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
            {dig3, dig2, dig1, dig0} <= (state == S_LAP) ? lap_cnt : cnt;
        end
    end

    assign running = (state == S_RUN) || (state == S_LAP);
endmodule

// File: tb/tb_stopwatch_bcd_ctl.sv
// tb/tb_stopwatch_bcd_ctl.sv - randomized bench for stopwatch_bcd_ctl against a seconds-based model
`timescale 1ns/1ps
module tb_stopwatch_bcd_ctl;
    localparam int PD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       running, wrap;

    stopwatch_bcd_ctl #(.DEB_LEN(16'(PD))) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wrap_seen = 0;
    bit tick_ev[int];
    bit start_ev[int];
    bit lap_ev[int];

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;
    mstate_t m_state = M_IDLE;
    int m_sec = 0, m_lap = 0, m_show = 0;
    bit m_wrap = 0;
    bit tp, sp, lp;

    function automatic logic [15:0] to_bcd(int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_state = M_IDLE;
        m_sec = 0;
        m_lap = 0;
        m_show = 0;
        m_wrap = 0;
        tick_ev.delete();
        start_ev.delete();
        lap_ev.delete();
    endtask

    always @(negedge rst_n) m_reset();

    // Reference: whole seconds, with events landing at known latencies after the raw input changes
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_reset();
        end else begin
            tp = tick_ev.exists(cyc);
            sp = start_ev.exists(cyc);
            lp = lap_ev.exists(cyc) && !sp;
            m_show = (m_state == M_LAP) ? m_lap : m_sec;
            m_wrap = 0;
            if (m_state == M_RUN && lp) m_lap = m_sec;
            if (m_state == M_PAUSE && lp) begin
                m_sec = 0;
            end else if (tp && (m_state == M_RUN || m_state == M_LAP)) begin
                if (m_sec == 3599) begin
                    m_sec = 0;
                    m_wrap = 1;
                end else begin
                    m_sec++;
                end
            end
            case (m_state)
                M_IDLE:  if (sp) m_state = M_RUN;
                M_RUN:   if (sp) m_state = M_PAUSE; else if (lp) m_state = M_LAP;
                M_PAUSE: if (sp) m_state = M_RUN; else if (lp) m_state = M_IDLE;
                M_LAP:   if (sp) m_state = M_PAUSE; else if (lp) m_state = M_RUN;
                default: m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("digits", {dig3, dig2, dig1, dig0}, to_bcd(m_show));
        check("running", running, (m_state == M_RUN || m_state == M_LAP));
        check("wrap", wrap, m_wrap);
        if (wrap) wrap_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once(input int hi, input int lo);
        step();
        tick = 1'b1;
        tick_ev[cyc + 3] = 1'b1;
        repeat (hi) step();
        tick = 1'b0;
        repeat (lo) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once(1, 2);
        repeat (4) step();
    endtask

    task automatic press(input bit s, input bit l);
        step();
        if (s) begin
            btn_start = 1'b1;
            start_ev[cyc + PD + 3] = 1'b1;
        end
        if (l) begin
            btn_lap = 1'b1;
            lap_ev[cyc + PD + 3] = 1'b1;
        end
        repeat (PD + 4) step();
        btn_start = 1'b0;
        btn_lap = 1'b0;
        repeat (PD + 4) step();
    endtask

    function automatic int shown();
        return int'({dig3, dig2, dig1, dig0});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_digits", shown(), 16'h0000);
        check("reset_running", running, 0);
        check("reset_wrap", wrap, 0);

        ticks(10);
        check("idle_ticks_digits", shown(), 16'h0000);
        check("idle_ticks_running", running, 0);

        press(1, 0);
        ticks(75);
        check("run75_digits", shown(), 16'h0115);
        check("run75_running", running, 1);

        press(1, 0);
        press(0, 1);
        check("clear_digits", shown(), 16'h0000);
        check("clear_running", running, 0);
        for (int i = 0; i < 8; i++) begin
            btn_start = 1'b1;
            repeat (3) step();
            btn_start = 1'b0;
            repeat (3) step();
        end
        btn_start = 1'b1;
        start_ev[cyc + PD + 3] = 1'b1;
        repeat (PD + 4) step();
        btn_start = 1'b0;
        repeat (PD + 4) step();
        check("bounce_running", running, 1);

        ticks(5);
        check("pre_lap_digits", shown(), 16'h0005);
        press(0, 1);
        ticks(3);
        check("lap_hold_digits", shown(), 16'h0005);
        check("lap_running", running, 1);
        press(0, 1);
        check("lap_release_digits", shown(), 16'h0008);

        ticks(3590);
        ticks(1);
        check("max_digits", shown(), 16'h5959);
        wrap_seen = 0;
        ticks(1);
        check("wrap_pulses", wrap_seen, 1);
        check("wrap_digits", shown(), 16'h0000);

        ticks(30);
        press(1, 0);
        check("pause_digits", shown(), 16'h0030);
        check("pause_running", running, 0);
        step();
        btn_lap = 1'b1;
        lap_ev[cyc + PD + 3] = 1'b1;
        repeat (PD) step();
        tick = 1'b1;
        tick_ev[cyc + 3] = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        btn_lap = 1'b0;
        repeat (PD + 4) step();
        check("clear_tick_digits", shown(), 16'h0000);
        check("clear_tick_running", running, 0);

        press(1, 0);
        ticks(3);
        check("prereset_digits", shown(), 16'h0003);
        step();
        tick = 1'b1;
        tick_ev[cyc + 3] = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        tick = 1'b0;
        #1;
        check("async_reset_digits", shown(), 16'h0000);
        check("async_reset_running", running, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("post_reset_digits", shown(), 16'h0000);
        check("post_reset_running", running, 0);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    tick_once($urandom_range(1, 3), $urandom_range(1, 4));
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    int sel;
                    sel = $urandom_range(0, 2);
                    repeat ($urandom_range(0, 40)) step();
                    press(sel != 1, sel != 0);
                end
            end
        join
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
